// File: rtl/vme_adapter_pkg.sv
// vme_adapter_pkg
//   Shared types and constants for the VME event adapter.
//   - cycle_state_t : bus cycle tracker states (IDLE, READ, WRITE)
//   - ERR_*         : protocol error codes; lower code has higher priority
package vme_adapter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } cycle_state_t;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_SET_SET  = 3'd1;
   localparam logic [2:0] ERR_CLR_CLR  = 3'd2;
   localparam logic [2:0] ERR_SET_CLR  = 3'd3;
   localparam logic [2:0] ERR_STROBE   = 3'd4;
   localparam logic [2:0] ERR_ACK_IDLE = 3'd5;

endpackage

// File: rtl/vme_edge_sync.sv
// vme_edge_sync
//   Synchronises one asynchronous level and turns its edges into registered
//   one-cycle pulses.
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   asynchronous active-high reset
//     a_i      in   asynchronous level
//     plus_o   out  one-cycle pulse after a synchronised 0->1 edge
//     minus_o  out  one-cycle pulse after a synchronised 1->0 edge
//   A change on a_i shows up as a pulse in the cycle after the
//   (SYNC_STAGES+1)th rising edge: SYNC_STAGES edges through the chain, one
//   more to register the pulse.
module vme_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic a_i,
   output logic plus_o,
   output logic minus_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   plus_q;
   logic                   minus_q;
   logic                   sync_w;

   assign sync_w = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         plus_q  <= 1'b0;
         minus_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], a_i};
         prev_q  <= sync_w;
         plus_q  <= sync_w & ~prev_q;
         minus_q <= ~sync_w & prev_q;
      end
   end

   assign plus_o  = plus_q;
   assign minus_o = minus_q;

endmodule

// File: rtl/vme_event_adapter.sv
// vme_event_adapter
//   Environment-side stage of the VME bus controller.
//   Ports:
//     clk, reset                   clock / async active-high reset
//     dsr, dsw, ldtack             asynchronous bus levels in
//     dsr_PLUS .. ldtack_MINUS     edge events to the controller (1-cycle)
//     d_MINUSa                     loopback event one cycle after d falls
//     lds_*, d_*, dtack_*          controller events driving the levels
//     lds, d, dtack                registered bus levels out
//     proto_err, err_code          sticky first-error flag and its code
//     cycle_state_o                cycle tracker state, for observation
//   Handshake: there is no valid/ready flow control. Every event is a
//   one-cycle pulse that is acted on in the cycle it is high; levels move on
//   the edge that samples the event.
module vme_event_adapter
   import vme_adapter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         dsr,
   input  logic         dsw,
   input  logic         ldtack,
   output logic         dsr_PLUS,
   output logic         dsr_MINUS,
   output logic         dsw_PLUS,
   output logic         dsw_MINUS,
   output logic         ldtack_PLUS,
   output logic         ldtack_PLUSa,
   output logic         ldtack_MINUS,
   output logic         d_MINUSa,
   input  logic         lds_PLUS,
   input  logic         lds_MINUS,
   input  logic         lds_MINUSa,
   input  logic         d_PLUS,
   input  logic         d_PLUSa,
   input  logic         d_MINUS,
   input  logic         dtack_PLUS,
   input  logic         dtack_PLUSa,
   input  logic         dtack_MINUS,
   output logic         lds,
   output logic         d,
   output logic         dtack,
   output logic         proto_err,
   output logic [2:0]   err_code,
   output cycle_state_t cycle_state_o
);

   // Bit positions in the packed level vectors.
   localparam int L_LDS = 2;
   localparam int L_D   = 1;
   localparam int L_DT  = 0;

   logic dsr_rise, dsr_fall, dsw_rise, dsw_fall, ack_rise, ack_fall;
   logic both_rise;

   vme_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dsr (
      .clk(clk), .reset(reset), .a_i(dsr),
      .plus_o(dsr_rise), .minus_o(dsr_fall));

   vme_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dsw (
      .clk(clk), .reset(reset), .a_i(dsw),
      .plus_o(dsw_rise), .minus_o(dsw_fall));

   vme_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
      .clk(clk), .reset(reset), .a_i(ldtack),
      .plus_o(ack_rise), .minus_o(ack_fall));

   assign both_rise = dsr_rise & dsw_rise;

   // ---------------------------------------------------------------- cycle FSM
   cycle_state_t state_q;
   logic         strobe_gone_q;   // strobe already fell, waiting for dtack_MINUS
   logic [2:0]   lvl_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         strobe_gone_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               strobe_gone_q <= 1'b0;
               if (!both_rise) begin
                  if (dsr_rise)      state_q <= READ;
                  else if (dsw_rise) state_q <= WRITE;
               end
            end
            READ: begin
               if (dsr_fall || strobe_gone_q) begin
                  if (!lvl_q[L_DT] || dtack_MINUS) begin
                     state_q       <= IDLE;
                     strobe_gone_q <= 1'b0;
                  end else begin
                     strobe_gone_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (dsw_fall || strobe_gone_q) begin
                  if (!lvl_q[L_DT] || dtack_MINUS) begin
                     state_q       <= IDLE;
                     strobe_gone_q <= 1'b0;
                  end else begin
                     strobe_gone_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q       <= IDLE;
               strobe_gone_q <= 1'b0;
            end
         endcase
      end
   end

   // Event outputs are ANDs of flops only: the pulses and the state are all
   // registered on the same clock, so no combinational input reaches them.
   // A simultaneous strobe rise suppresses both PLUS pulses.
   assign dsr_PLUS     = dsr_rise & ~dsw_rise;
   assign dsw_PLUS     = dsw_rise & ~dsr_rise;
   assign dsr_MINUS    = dsr_fall;
   assign dsw_MINUS    = dsw_fall;
   assign ldtack_PLUS  = ack_rise & (state_q != WRITE);
   assign ldtack_PLUSa = ack_rise & (state_q == WRITE);
   assign ldtack_MINUS = ack_fall;

   // ---------------------------------------------------------------- levels
   logic [2:0] set_w, clr_w, lvl_d;
   logic       d_prev_q, d_minusa_q;
   logic       proto_err_q;
   logic [2:0] err_code_q, err_now;

   assign set_w = {lds_PLUS, d_PLUS | d_PLUSa, dtack_PLUS | dtack_PLUSa};
   assign clr_w = {lds_MINUS | lds_MINUSa, d_MINUS, dtack_MINUS};

   // Set-only -> 1, clear-only -> 0, both or neither -> hold.
   assign lvl_d = (lvl_q & ~(clr_w & ~set_w)) | (set_w & ~clr_w);

   // Lowest code wins when several errors occur in the same cycle.
   always_comb begin
      err_now = ERR_NONE;
      if (|(set_w & ~clr_w & lvl_q))
         err_now = ERR_SET_SET;
      else if (|(clr_w & ~set_w & ~lvl_q))
         err_now = ERR_CLR_CLR;
      else if (|(set_w & clr_w))
         err_now = ERR_SET_CLR;
      else if (both_rise || (state_q == READ && dsw_rise) ||
               (state_q == WRITE && dsr_rise))
         err_now = ERR_STROBE;
      else if (ack_rise && state_q == IDLE)
         err_now = ERR_ACK_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_q       <= 3'b000;
         d_prev_q    <= 1'b0;
         d_minusa_q  <= 1'b0;
         proto_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         lvl_q      <= lvl_d;
         d_prev_q   <= lvl_q[L_D];
         d_minusa_q <= d_prev_q & ~lvl_q[L_D];
         if (!proto_err_q && err_now != ERR_NONE) begin
            proto_err_q <= 1'b1;
            err_code_q  <= err_now;
         end
      end
   end

   assign lds           = lvl_q[L_LDS];
   assign d             = lvl_q[L_D];
   assign dtack         = lvl_q[L_DT];
   assign d_MINUSa      = d_minusa_q;
   assign proto_err     = proto_err_q;
   assign err_code      = err_code_q;
   assign cycle_state_o = state_q;

endmodule

// File: tb/tb_vme_event_adapter.sv
// tb_vme_event_adapter
//   Drives bus levels and controller events; expected event pulses are queued
//   with the cycle in which they must appear and matched by a monitor.
module tb_vme_event_adapter;
   import vme_adapter_pkg::*;

   // ------------------------------------------------------------ clock/reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------ DUT
   logic dsr = 1'b0, dsw = 1'b0, ldtack = 1'b0;
   logic [8:0] ctl = '0;
   logic dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS;
   logic ldtack_PLUS, ldtack_PLUSa, ldtack_MINUS, d_MINUSa;
   logic lds, d, dtack, proto_err;
   logic [2:0] err_code;
   cycle_state_t cycle_state_o;

   localparam int C_LDS_P = 0, C_LDS_M = 1, C_LDS_MA = 2;
   localparam int C_D_P = 3, C_D_PA = 4, C_D_M = 5;
   localparam int C_DT_P = 6, C_DT_PA = 7, C_DT_M = 8;

   localparam logic [7:0] P_DSR_P = 8'h80, P_DSR_M = 8'h40;
   localparam logic [7:0] P_DSW_P = 8'h20, P_DSW_M = 8'h10;
   localparam logic [7:0] P_ACK_P = 8'h08, P_ACK_PA = 8'h04;
   localparam logic [7:0] P_ACK_M = 8'h02, P_D_MA = 8'h01;

   vme_event_adapter #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .dsr(dsr), .dsw(dsw), .ldtack(ldtack),
      .dsr_PLUS(dsr_PLUS), .dsr_MINUS(dsr_MINUS),
      .dsw_PLUS(dsw_PLUS), .dsw_MINUS(dsw_MINUS),
      .ldtack_PLUS(ldtack_PLUS), .ldtack_PLUSa(ldtack_PLUSa),
      .ldtack_MINUS(ldtack_MINUS), .d_MINUSa(d_MINUSa),
      .lds_PLUS(ctl[C_LDS_P]), .lds_MINUS(ctl[C_LDS_M]), .lds_MINUSa(ctl[C_LDS_MA]),
      .d_PLUS(ctl[C_D_P]), .d_PLUSa(ctl[C_D_PA]), .d_MINUS(ctl[C_D_M]),
      .dtack_PLUS(ctl[C_DT_P]), .dtack_PLUSa(ctl[C_DT_PA]), .dtack_MINUS(ctl[C_DT_M]),
      .lds(lds), .d(d), .dtack(dtack),
      .proto_err(proto_err), .err_code(err_code),
      .cycle_state_o(cycle_state_o)
   );

   logic [7:0] pulses;
   assign pulses = {dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS,
                    ldtack_PLUS, ldtack_PLUSa, ldtack_MINUS, d_MINUSa};

   // ------------------------------------------------------------ scoreboard
   int checks = 0;
   int errors = 0;
   logic [39:0] exp_q[$];   // {cycle[31:0], pulse vector[7:0]}

   task automatic push_exp(input int unsigned dly, input logic [7:0] v);
      exp_q.push_back({cyc + dly, v});
   endtask

   always @(negedge clk) begin
      logic [39:0] e;
      if (!reset) begin
         while (exp_q.size() > 0 && exp_q[0][39:8] < cyc) begin
            e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missed_pulse: expected %h at cycle %0d, now cycle %0d",
                     e[7:0], e[39:8], cyc);
         end
         if (pulses != 8'h00) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: got %h at cycle %0d, none expected",
                        pulses, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e[7:0] !== pulses || e[39:8] !== cyc) begin
                  errors++;
                  $display("FAIL pulse: got %h at cycle %0d, expected %h at cycle %0d",
                           pulses, cyc, e[7:0], e[39:8]);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ drivers
   task automatic drive_ctl(input logic [8:0] v);
      ctl = v;
      @(negedge clk);
      ctl = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wait_cycles(2);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      wait_cycles(3);
      checks++;
      if ({pulses, lds, d, dtack, proto_err, err_code} !== 15'd0 || cycle_state_o !== IDLE) begin
         errors++;
         $display("FAIL reset_outputs: pulses=%h lds=%b d=%b dtack=%b err=%b code=%0d state=%0d, expected all 0",
                  pulses, lds, d, dtack, proto_err, err_code, cycle_state_o);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read();
      push_exp(3, P_DSR_P);
      dsr = 1'b1;
      wait_cycles(4);
      checks++;
      if (cycle_state_o !== READ) begin
         errors++; $display("FAIL read_state: got %0d expected READ", cycle_state_o);
      end
      push_exp(3, P_ACK_P);
      ldtack = 1'b1;
      wait_cycles(4);
      drive_ctl(9'd1 << C_LDS_P);
      checks++;
      if (lds !== 1'b1) begin errors++; $display("FAIL read_lds_set: got %b expected 1", lds); end
      idle_gap();
      drive_ctl(9'd1 << C_D_P);
      checks++;
      if (d !== 1'b1) begin errors++; $display("FAIL read_d_set: got %b expected 1", d); end
      idle_gap();
      drive_ctl(9'd1 << C_DT_P);
      checks++;
      if (dtack !== 1'b1) begin errors++; $display("FAIL read_dtack_set: got %b expected 1", dtack); end
      push_exp(3, P_DSR_M);
      dsr = 1'b0;
      wait_cycles(4);
      checks++;
      if (cycle_state_o !== READ) begin
         errors++; $display("FAIL read_hold_for_dtack: got %0d expected READ", cycle_state_o);
      end
      push_exp(2, P_D_MA);
      drive_ctl(9'd1 << C_D_M);
      checks++;
      if (d !== 1'b0) begin errors++; $display("FAIL read_d_clr: got %b expected 0", d); end
      wait_cycles(2);
      drive_ctl(9'd1 << C_LDS_M);
      checks++;
      if (lds !== 1'b0) begin errors++; $display("FAIL read_lds_clr: got %b expected 0", lds); end
      push_exp(3, P_ACK_M);
      ldtack = 1'b0;
      wait_cycles(4);
      drive_ctl(9'd1 << C_DT_M);
      checks++;
      if (dtack !== 1'b0 || cycle_state_o !== IDLE || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL read_end: dtack=%b state=%0d err=%b expected 0 IDLE 0",
                  dtack, cycle_state_o, proto_err);
      end
      idle_gap();
   endtask

   task automatic test_write();
      push_exp(3, P_DSW_P);
      dsw = 1'b1;
      wait_cycles(4);
      checks++;
      if (cycle_state_o !== WRITE) begin
         errors++; $display("FAIL write_state: got %0d expected WRITE", cycle_state_o);
      end
      push_exp(3, P_ACK_PA);
      ldtack = 1'b1;
      wait_cycles(4);
      drive_ctl(9'd1 << C_LDS_P);
      idle_gap();
      drive_ctl(9'd1 << C_DT_PA);
      checks++;
      if (dtack !== 1'b1) begin errors++; $display("FAIL write_dtack_set: got %b expected 1", dtack); end
      push_exp(3, P_DSW_M);
      dsw = 1'b0;
      wait_cycles(4);
      checks++;
      if (cycle_state_o !== WRITE) begin
         errors++; $display("FAIL write_hold_for_dtack: got %0d expected WRITE", cycle_state_o);
      end
      drive_ctl(9'd1 << C_DT_M);
      checks++;
      if (cycle_state_o !== IDLE) begin
         errors++; $display("FAIL write_to_idle: got %0d expected IDLE", cycle_state_o);
      end
      drive_ctl(9'd1 << C_LDS_MA);
      push_exp(3, P_ACK_M);
      ldtack = 1'b0;
      wait_cycles(4);
      checks++;
      if (proto_err !== 1'b0 || lds !== 1'b0) begin
         errors++; $display("FAIL write_clean: err=%b lds=%b expected 0 0", proto_err, lds);
      end
   endtask

   task automatic test_simultaneous();
      dsr = 1'b1;
      dsw = 1'b1;
      wait_cycles(4);
      checks++;
      if (cycle_state_o !== IDLE || proto_err !== 1'b1 || err_code !== ERR_STROBE) begin
         errors++;
         $display("FAIL simul_rise: state=%0d err=%b code=%0d expected IDLE 1 4",
                  cycle_state_o, proto_err, err_code);
      end
      push_exp(3, P_DSR_M | P_DSW_M);
      dsr = 1'b0;
      dsw = 1'b0;
      wait_cycles(4);
      do_reset();
   endtask

   task automatic test_strobe_cross();
      push_exp(3, P_DSR_P);
      dsr = 1'b1;
      wait_cycles(4);
      push_exp(3, P_DSW_P);
      dsw = 1'b1;
      wait_cycles(4);
      checks++;
      if (cycle_state_o !== READ || err_code !== ERR_STROBE) begin
         errors++;
         $display("FAIL strobe_cross: state=%0d code=%0d expected READ 4", cycle_state_o, err_code);
      end
      push_exp(3, P_DSR_M | P_DSW_M);
      dsr = 1'b0;
      dsw = 1'b0;
      wait_cycles(4);
      checks++;
      if (cycle_state_o !== IDLE) begin
         errors++; $display("FAIL strobe_cross_idle: got %0d expected IDLE", cycle_state_o);
      end
      do_reset();
   endtask

   task automatic test_ack_idle();
      push_exp(3, P_ACK_P);
      ldtack = 1'b1;
      wait_cycles(4);
      checks++;
      if (proto_err !== 1'b1 || err_code !== ERR_ACK_IDLE) begin
         errors++; $display("FAIL ack_idle: err=%b code=%0d expected 1 5", proto_err, err_code);
      end
      push_exp(3, P_ACK_M);
      ldtack = 1'b0;
      wait_cycles(4);
      do_reset();
   endtask

   task automatic test_set_set();
      drive_ctl(9'd1 << C_D_P);
      idle_gap();
      drive_ctl(9'd1 << C_D_PA);
      checks++;
      if (d !== 1'b1 || proto_err !== 1'b1 || err_code !== ERR_SET_SET) begin
         errors++;
         $display("FAIL set_set: d=%b err=%b code=%0d expected 1 1 1", d, proto_err, err_code);
      end
      push_exp(2, P_D_MA);
      drive_ctl(9'd1 << C_D_M);
      wait_cycles(2);
      drive_ctl(9'd1 << C_D_M);
      checks++;
      if (d !== 1'b0 || err_code !== ERR_SET_SET) begin
         errors++; $display("FAIL first_err_kept: d=%b code=%0d expected 0 1", d, err_code);
      end
      wait_cycles(3);
      do_reset();
   endtask

   task automatic test_set_clr();
      drive_ctl((9'd1 << C_LDS_P) | (9'd1 << C_LDS_MA));
      checks++;
      if (lds !== 1'b0 || err_code !== ERR_SET_CLR) begin
         errors++; $display("FAIL set_clr: lds=%b code=%0d expected 0 3", lds, err_code);
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      drive_ctl(9'd1 << C_D_P);
      dsr = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({pulses, lds, d, dtack, proto_err, err_code} !== 15'd0 || cycle_state_o !== IDLE) begin
         errors++;
         $display("FAIL reset_mid: pulses=%h d=%b err=%b code=%0d state=%0d expected all 0",
                  pulses, d, proto_err, err_code, cycle_state_o);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      push_exp(3, P_DSR_P);
      wait_cycles(5);
      checks++;
      if (cycle_state_o !== READ) begin
         errors++; $display("FAIL reset_mid_resync: got %0d expected READ", cycle_state_o);
      end
      push_exp(3, P_DSR_M);
      dsr = 1'b0;
      wait_cycles(4);
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      test_reset();
      test_read();
      test_write();
      test_simultaneous();
      test_strobe_cross();
      test_ack_idle();
      test_set_set();
      test_set_clr();
      test_reset_mid();
      wait_cycles(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL queue_drained: %0d pulses still expected", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
